// File: rtl/ifp_pkg.sv
// ifp_pkg: shared types and constants for the instruction fetch unit.
// Fetch-queue entries carry a 64-bit PC slot; narrower XLEN zero-extends.
`ifndef DRAM_BASE_ADDR
`define DRAM_BASE_ADDR 64'h0000_0000_8000_0000
`endif

package ifp_pkg;

  localparam int unsigned PC_W = 64;

  localparam logic [2:0] RD_CTRL_DRAM = 3'b101;
  localparam logic [2:0] RD_CTRL_NONE = 3'b000;

  typedef enum logic {
    INIT,
    RUN
  } fsm_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifp_sync_fifo.sv
// ifp_sync_fifo: synchronous FIFO with occupancy count and flush.
// Push while full is accepted only if a pop frees a slot that cycle.
module ifp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifp_fetch_unit.sv
// ifp_fetch_unit: in-order instruction fetch with credit-limited requests,
// branch redirect that drops stale responses, and a decode-side queue.
`ifndef DRAM_BASE_ADDR
`define DRAM_BASE_ADDR 64'h0000_0000_8000_0000
`endif

module ifp_fetch_unit
  import ifp_pkg::*;
#(
  parameter int unsigned     XLEN            = 64,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter logic [XLEN-1:0] DRAM_BASE       = `DRAM_BASE_ADDR,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter int unsigned     FQ_DEPTH        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic            req_sel,
  output logic [2:0]      req_rd_ctrl,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            err
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned EW = $bits(fetch_entry_t);

  fsm_e            state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   drop_q, drop_d;
  logic            err_q, err_d;

  logic [PW-1:0]   inflight;
  logic [XLEN-1:0] pend_pc;
  logic [CW-1:0]   fq_cnt;
  logic [EW-1:0]   fq_dout;
  fetch_entry_t    fq_din;
  fetch_entry_t    fq_head;
  logic [CW:0]     credit_use;

  logic run;
  logic brk;
  logic rsp_ok;
  logic accept;
  logic fq_push;
  logic fq_pop;
  logic unused_tgt;

  assign unused_tgt = ^branch_target[1:0];

  assign run    = (state_q == RUN);
  assign brk    = run && branch_taken;
  assign rsp_ok = rsp_valid && (inflight != '0);

  // Live requests still need a fetch-queue slot when they return.
  assign credit_use = (CW+1)'(inflight - drop_q)
                    + (CW+1)'(fq_cnt);

  assign req_valid = run && !branch_taken
                  && (inflight < PW'(MAX_OUTSTANDING))
                  && (credit_use < (CW+1)'(FQ_DEPTH));
  assign accept    = req_valid && req_ready;

  assign req_addr    = pc_q;
  assign req_sel     = (pc_q >= DRAM_BASE);
  assign req_rd_ctrl = req_sel ? RD_CTRL_DRAM : RD_CTRL_NONE;

  assign fq_push = rsp_ok && !brk && (drop_q == '0);
  assign fq_pop  = out_valid && out_ready;

  assign fq_din.pc    = PC_W'(pend_pc);
  assign fq_din.instr = rsp_data;
  assign fq_head      = fetch_entry_t'(fq_dout);

  assign out_valid = (fq_cnt != '0) && !branch_taken;
  assign out_pc    = (fq_cnt != '0) ? fq_head.pc[XLEN-1:0] : '0;
  assign out_instr = (fq_cnt != '0) ? fq_head.instr : '0;
  assign err       = err_q;

  ifp_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (accept),
    .din_i   (pc_q),
    .pop_i   (rsp_ok),
    .dout_o  (pend_pc),
    .count_o (inflight)
  );

  ifp_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .reset   (reset),
    .flush_i (brk),
    .push_i  (fq_push),
    .din_i   (fq_din),
    .pop_i   (fq_pop),
    .dout_o  (fq_dout),
    .count_o (fq_cnt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    err_d   = err_q | (rsp_valid && (inflight == '0));
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (branch_taken) begin
          pc_d   = {branch_target[XLEN-1:2], 2'b00};
          drop_d = inflight - PW'(rsp_ok);
        end else begin
          if (accept) pc_d = pc_q + XLEN'(4);
          if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - PW'(1);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

endmodule
